// File: rtl/riscv_fetch.sv
// Instruction fetch unit: one outstanding imem request, small in-order instruction buffer, redirect flush.
// Optional RISCV_FETCH_MISALIGN_EN: misaligned redirect raises sticky fetch_fault and halts fetch.
package riscv_fetch_pkg;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fetch_entry_t    ent_q [BUF_DEPTH];
    fetch_entry_t    ent_d [BUF_DEPTH];
    logic            req_q, req_d;
    logic            vld_q, vld_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] redir_pc_c;
    logic            misalign_c;
    logic            redir_c;
    logic            grant_c;
    logic            push_c;
    logic            pop_c;
    logic [IDX_W-1:0] wr_idx_c;

`ifdef RISCV_FETCH_MISALIGN_EN
    assign redir_pc_c = redirect_pc;
    assign misalign_c = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_lsb_c;
    assign unused_lsb_c = ^redirect_pc[1:0];
    assign redir_pc_c   = {redirect_pc[XLEN-1:2], 2'b00};
    assign misalign_c   = 1'b0;
`endif

    // Handshake qualifiers; a redirect suppresses both push and pop.
    always_comb begin
        redir_c  = redirect_valid && (state_q != HALT);
        grant_c  = req_q && imem_gnt;
        pop_c    = vld_q && instr_ready && !redir_c;
        push_c   = (state_q == WAIT) && imem_rvalid && !drop_q && !redir_c &&
                   ((cnt_q != CNT_W'(BUF_DEPTH)) || pop_c);
        wr_idx_c = IDX_W'(cnt_q - CNT_W'(pop_c));
    end

    // Next-state, buffer and output computation.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        ent_d    = ent_q;
        req_d    = 1'b0;
        vld_d    = 1'b0;

        if (pop_c) begin
            for (int unsigned i = 0; i + 1 < BUF_DEPTH; i++) begin
                ent_d[i] = ent_q[i + 1];
            end
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (push_c) begin
            ent_d[wr_idx_c] = '{data: imem_rdata, pc: req_pc_q};
            cnt_d           = cnt_d + CNT_W'(1);
        end
        if (grant_c) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end

        case (state_q)
            IDLE: if (cnt_d < CNT_W'(BUF_DEPTH)) state_d = REQ;
            REQ:  if (grant_c) state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = (cnt_d < CNT_W'(BUF_DEPTH)) ? REQ : IDLE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // A request still in flight after a redirect belongs to the old path.
        if (redir_c) begin
            cnt_d = '0;
            if (misalign_c) begin
                fault_d = 1'b1;
                drop_d  = 1'b0;
                state_d = HALT;
            end else begin
                pc_d = redir_pc_c;
                if (state_d == WAIT) drop_d = 1'b1;
                if (state_d == IDLE) state_d = REQ;
            end
        end

        req_d = (state_d == REQ) && (cnt_d < CNT_W'(BUF_DEPTH));
        vld_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            vld_q    <= 1'b0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            vld_q    <= vld_d;
            ent_q    <= ent_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = vld_q;
    assign instr_data  = ent_q[0].data;
    assign instr_pc    = ent_q[0].pc;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// Randomized bench for riscv_fetch against a stream-level model of the expected fetch path.
module tb_riscv_fetch;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef RISCV_FETCH_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    always #5 clk = ~clk;

    riscv_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    // Model: expected PCs in the buffer, the path's next fetch PC and the single in-flight request.
    logic [31:0] q_pc[$];
    logic [31:0] m_fetch, out_pc, mem_addr, last_gnt, wrap_addr, cap_pc, prev_pc, prev_data, frc_tgt;
    logic        m_out, m_halt, frc_redir, stray, cap_arm, cap_seen, wrap_seen, stall_prev;
    int          m_epoch, out_epoch, dly, since_rst, n_acc;
    int          p_gnt, p_rdy, p_redir, max_dly;
    logic [31:0] acc_log [4];

    task automatic do_reset();
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        chk_eq("rst_req",   32'(imem_req), 0);
        chk_eq("rst_valid", 32'(instr_valid), 0);
        chk_eq("rst_data",  instr_data, 0);
        chk_eq("rst_pc",    instr_pc, 0);
        chk_eq("rst_fault", 32'(fetch_fault), 0);
        q_pc.delete();
        m_fetch = RST_PC; m_out = 1'b0; m_halt = 1'b0; m_epoch++; dly = 0;
        frc_redir = 1'b0; stray = 1'b0; cap_arm = 1'b0; stall_prev = 1'b0;
        since_rst = 0; n_acc = 0;
        rst = 1'b0;
    endtask

    // One clock: check at the falling edge, drive, then advance the model at the rising edge.
    task automatic cycle();
        logic        s_req, s_vld, acc, grant;
        logic [31:0] s_addr, s_pc, s_data;
        since_rst++;
        s_req = imem_req; s_addr = imem_addr; s_vld = instr_valid; s_pc = instr_pc; s_data = instr_data;

        chk_eq("valid", 32'(s_vld), 32'(q_pc.size() != 0));
        chk_eq("fault", 32'(fetch_fault), 32'(m_halt));
        if (s_req) begin
            chk_eq("addr", s_addr, m_fetch);
            chk_eq("one_outstanding", 32'(m_out), 0);
            chk_eq("room", 32'(q_pc.size() < DEPTH), 1);
            chk_eq("req_halted", 32'(m_halt), 0);
        end
        if (stall_prev) begin
            chk_eq("hold_pc", s_pc, prev_pc);
            chk_eq("hold_data", s_data, prev_data);
        end
        if (since_rst == 1) chk_eq("req_t1", 32'(s_req), 0);
        if (since_rst == 2) begin
            chk_eq("req_t2", 32'(s_req), 1);
            chk_eq("first_addr", s_addr, RST_PC);
        end

        imem_gnt       = ($urandom_range(0, 99) < p_gnt);
        instr_ready    = ($urandom_range(0, 99) < p_rdy);
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (frc_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = frc_tgt;
            frc_redir      = 1'b0;
        end else if ($urandom_range(0, 99) < p_redir) begin
            redirect_valid = 1'b1;
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            else                           redirect_pc = 32'($urandom_range(0, 1023)) * 32'd4;
            if (!MIS_EN) redirect_pc[1:0] = 2'($urandom_range(0, 3));
        end
        imem_rvalid = stray || (m_out && dly == 0);
        imem_rdata  = (m_out && dly == 0) ? mem_word(mem_addr) : $urandom;

        @(posedge clk);
        acc = s_vld && instr_ready && !redirect_valid;
        if (acc && q_pc.size() != 0) begin
            chk_eq("instr_pc", s_pc, q_pc[0]);
            chk_eq("instr_data", s_data, mem_word(q_pc[0]));
            if (n_acc < 4) acc_log[n_acc] = s_pc;
            n_acc++;
            if (cap_arm) begin cap_pc = s_pc; cap_seen = 1'b1; cap_arm = 1'b0; end
            void'(q_pc.pop_front());
        end
        if (imem_rvalid && m_out) begin
            m_out = 1'b0;
            if (out_epoch == m_epoch && !redirect_valid && !m_halt) q_pc.push_back(out_pc);
        end else if (m_out) begin
            dly--;
        end
        grant = s_req && imem_gnt;
        if (grant) begin
            m_out = 1'b1; out_epoch = m_epoch; out_pc = m_fetch; mem_addr = s_addr;
            dly = $urandom_range(0, max_dly);
            if (last_gnt == 32'hFFFF_FFFC) begin wrap_seen = 1'b1; wrap_addr = s_addr; end
            last_gnt = s_addr;
            m_fetch  = m_fetch + 32'd4;
        end
        if (redirect_valid && !m_halt) begin
            m_epoch++;
            q_pc.delete();
            if (MIS_EN && redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
            else                                      m_fetch = {redirect_pc[31:2], 2'b00};
        end
        stall_prev = s_vld && !instr_ready && !redirect_valid;
        prev_pc = s_pc; prev_data = s_data;
        stray = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_knobs(input int g, input int r, input int d, input int rd);
        p_gnt = g; p_rdy = r; max_dly = d; p_redir = rd;
    endtask

    initial begin
        int base;
        m_epoch = 0; last_gnt = '0; wrap_addr = 32'hDEAD_BEEF; wrap_seen = 1'b0; cap_seen = 1'b0;
        set_knobs(100, 100, 0, 0);
        do_reset();

        // Back-to-back streaming from reset.
        repeat (16) cycle();
        for (int i = 0; i < 4; i++) chk_eq("seq", acc_log[i], RST_PC + 32'(i) * 32'd4);

        // Decode stall fills the buffer, then drains in order with no new grants.
        set_knobs(100, 0, 0, 0);
        repeat (10) cycle();
        chk_eq("stall_req", 32'(imem_req), 0);
        chk_eq("stall_valid", 32'(instr_valid), 1);
        set_knobs(0, 100, 0, 0);
        base = n_acc;
        repeat (3 * DEPTH + 4) cycle();
        chk_eq("drain_cnt", 32'(n_acc - base), DEPTH);

        // Redirect while a request is in flight.
        set_knobs(100, 100, 2, 0);
        for (int i = 0; i < 20 && !m_out; i++) cycle();
        chk_eq("wait_reached", 32'(m_out), 1);
        dly = 2; frc_redir = 1'b1; frc_tgt = 32'h100; cap_arm = 1'b1; cap_seen = 1'b0;
        for (int i = 0; i < 40 && !cap_seen; i++) cycle();
        chk_eq("redir_seen", 32'(cap_seen), 1);
        chk_eq("redir_pc", cap_pc, 32'h100);

        // Fetch PC wraps from the top of the address space.
        set_knobs(100, 100, 0, 0);
        frc_redir = 1'b1; frc_tgt = 32'hFFFF_FFF8; last_gnt = '0; wrap_seen = 1'b0;
        repeat (20) cycle();
        chk_eq("wrap_seen", 32'(wrap_seen), 1);
        chk_eq("wrap_addr", wrap_addr, 32'h0);

        // Random traffic with redirects.
        set_knobs(70, 60, 3, 5);
        repeat (3000) cycle();

        // Misaligned redirect.
        set_knobs(100, 100, 0, 0);
        frc_redir = 1'b1; frc_tgt = 32'h102; cap_arm = 1'b1; cap_seen = 1'b0;
        for (int i = 0; i < 30 && (MIS_EN || !cap_seen); i++) cycle();
        if (MIS_EN) begin
            chk_eq("halt_fault", 32'(fetch_fault), 1);
            chk_eq("halt_req", 32'(imem_req), 0);
        end else begin
            chk_eq("align_seen", 32'(cap_seen), 1);
            chk_eq("align_pc", cap_pc, 32'h100);
        end
        do_reset();

        // Reset while waiting, then a stray response for the abandoned request.
        set_knobs(100, 100, 3, 0);
        for (int i = 0; i < 20 && !m_out; i++) cycle();
        chk_eq("wait_reached2", 32'(m_out), 1);
        dly = 3;
        do_reset();
        set_knobs(0, 100, 0, 0);
        stray = 1'b1; cycle();
        stray = 1'b1; cycle();
        cycle();
        set_knobs(100, 100, 0, 0);
        repeat (12) cycle();
        chk_eq("post_rst_pc", acc_log[0], RST_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
